rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter N, default 8, number of request lines and width of the one-hot grant; fixed at 8 for the 8-to-3 encoding stage.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  level-sensitive request lines; bit i = requester i.
REQ-005 grant  output  8  registered one-hot grant; drives the downstream 8-to-3 encoder input.
REQ-006 grant_valid  output  1  grant holds a valid one-hot value.
REQ-007 grant_ready  input  1  downstream accepts grant; handshake completes when grant_valid and grant_ready are both 1 on a rising edge.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (grant_valid=0) and GRANT (grant_valid=1).
REQ-009 IDLE: when req!=0 on a rising edge, the block SHALL register the round-robin winner into grant, set grant_valid=1 and enter GRANT; latency from sampled req to grant_valid is 1 cycle.
REQ-010 IDLE with req==0 SHALL hold grant=0, grant_valid=0.
REQ-011 Round-robin pick SHALL be the lowest index i >= ptr with req[i]=1; if none exists, the lowest index i < ptr with req[i]=1 (wrap 7->0).
REQ-012 GRANT with grant_ready=0 SHALL hold grant and grant_valid stable regardless of req changes, including deassertion of the granted line.
REQ-013 On handshake, ptr SHALL update to (granted index + 1) mod 8; granted index 7 wraps ptr to 0.
REQ-014 On handshake with req!=0 in the same cycle, the block SHALL register a new winner using the updated ptr and stay in GRANT, giving back-to-back grants with no idle cycle.
REQ-015 On handshake with req==0, the block SHALL clear grant to 0 and grant_valid to 0 and return to IDLE.
REQ-016 When grant_valid=1, grant SHALL have exactly one bit set; when grant_valid=0, grant SHALL be 8'b0.
REQ-017 A requester that holds req continuously SHALL be granted within 8 handshakes (starvation-free).

Reset
REQ-018 rst_n=0 SHALL asynchronously force grant=0, grant_valid=0, ptr=0 (req[0] highest priority) and state=IDLE.
REQ-019 Reset asserted while in GRANT SHALL discard the outstanding grant; no handshake is implied.
REQ-020 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with req!=0.

Structure
REQ-021 A shared package arb_pkg SHALL hold N, the IDLE/GRANT state encoding and the 3-bit pointer width.
REQ-022 Round-robin selection SHALL be a combinational sub-module rr_arbiter_8_pick (inputs req and ptr; output one-hot pick and 3-bit index).
REQ-023 The top level SHALL contain the FSM, the ptr register and the grant/grant_valid registers only.

Verification
REQ-024 Reset, then req=8'b00000001 and grant_ready=1: one cycle later grant=8'b00000001 and grant_valid=1; encoder out=3'b000.
REQ-025 req=8'b10000001 held and grant_ready=1: successive grants are 00000001, 10000000, 00000001, 10000000 with grant_valid continuously 1.
REQ-026 req=8'b11111111 held and grant_ready=1: 9 consecutive grants are 01,02,04,08,10,20,40,80,01 (hex), confirming the 7->0 pointer wrap.
REQ-027 req=8'b00000100 and grant_ready=0 for 5 cycles, then req drops to 0: grant stays 8'b00000100 with grant_valid=1 until grant_ready=1; the next cycle gives grant=0 and grant_valid=0.
REQ-028 rst_n driven low mid-cycle while grant_valid=1: grant=0 and grant_valid=0 immediately without a clock edge; after release, req=8'b00000011 grants 8'b00000001 (ptr=0).
REQ-029 req=0 for 10 cycles after reset: grant_valid stays 0 and grant stays 8'b0 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths and state encoding for the round-robin arbiter
package arb_pkg;

  localparam int N     = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// rtl/rr_arbiter_8_pick.sv - combinational round-robin selection
// Scans upward from ptr and wraps past the top, so ptr is the highest-priority line.
module rr_arbiter_8_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [PTR_W-1:0] idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // 3-bit add wraps 7->0 for free
      cand = ptr + i[PTR_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) pick[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with registered one-hot grant handshake
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N = arb_pkg::N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  input  logic         grant_ready
);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] pick_ptr;
  logic [N-1:0]     pick;
  logic [PTR_W-1:0] pick_idx;

  assign next_ptr = grant_idx + 1'b1;
  // While granting, the only pick that matters is the back-to-back one after a handshake
  assign pick_ptr = (state == GRANT) ? next_ptr : ptr;

  rr_arbiter_8_pick u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= pick;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr <= next_ptr;
            if (|req) begin
              grant     <= pick;
              grant_idx <= pick_idx;
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic       grant_ready;

  int tests = 0;
  int fails = 0;

  rr_arbiter_8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: next owner is the first requester met walking upward from the pointer
  int         m_ptr;
  int         m_idx;
  logic [7:0] m_grant;
  logic       m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   = 0;
      m_idx   = 0;
      m_grant = 8'h00;
      m_valid = 1'b0;
    end else if (!m_valid || grant_ready) begin
      int  w;
      bit  hit;
      if (m_valid) m_ptr = (m_idx + 1) % 8;
      hit = 1'b0;
      w   = 0;
      for (int k = 0; k < 8; k++) begin
        if (!hit && req[(m_ptr + k) % 8]) begin
          hit = 1'b1;
          w   = (m_ptr + k) % 8;
        end
      end
      if (hit) begin
        m_idx   = w;
        m_grant = 8'h01 << w;
        m_valid = 1'b1;
      end else begin
        m_grant = 8'h00;
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_grant", grant, m_grant);
      chk("model_valid", {7'b0, grant_valid}, {7'b0, m_valid});
      chk("onehot", {7'b0, (grant_valid ? $onehot(grant) : (grant == 8'h00))}, 8'h01);
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    req         = 8'h00;
    grant_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Lets one rising edge act on the current inputs and lands on the following falling edge
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] r;
    logic       rdy;
  } vec_t;

  logic [7:0] seq25 [4]  = '{8'h01, 8'h80, 8'h01, 8'h80};
  logic [7:0] seq26 [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  vec_t       mix   [14] = '{
    '{8'h5a, 1'b1}, '{8'h5a, 1'b0}, '{8'h5a, 1'b1}, '{8'h24, 1'b1},
    '{8'h00, 1'b1}, '{8'h00, 1'b0}, '{8'h81, 1'b0}, '{8'hc3, 1'b1},
    '{8'hc3, 1'b1}, '{8'h10, 1'b1}, '{8'h10, 1'b0}, '{8'hff, 1'b1},
    '{8'h06, 1'b1}, '{8'h00, 1'b1}
  };

  initial begin
    logic [7:0] seen;
    int         enc;

    rst_n       = 1'b0;
    req         = 8'h00;
    grant_ready = 1'b0;
    @(negedge clk);
    chk("reset_grant", grant, 8'h00);
    chk("reset_valid", {7'b0, grant_valid}, 8'h00);
    do_reset();

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_grant", grant, 8'h00);
      chk("idle_valid", {7'b0, grant_valid}, 8'h00);
    end

    // Single requester, one-cycle latency
    req         = 8'h01;
    grant_ready = 1'b1;
    cycle();
    chk("first_grant", grant, 8'h01);
    chk("first_valid", {7'b0, grant_valid}, 8'h01);
    enc = 0;
    for (int i = 0; i < 8; i++) if (grant[i]) enc = i;
    chk("first_enc", enc[7:0], 8'h00);

    do_reset();
    req         = 8'h81;
    grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_grant", grant, seq25[i]);
      chk("alt_valid", {7'b0, grant_valid}, 8'h01);
    end

    do_reset();
    req         = 8'hff;
    grant_ready = 1'b1;
    seen        = 8'h00;
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("all_grant", grant, seq26[i]);
      if (i < 8) seen |= grant;
    end
    chk("all_covered", seen, 8'hff);

    // Stalled grant survives request changes
    do_reset();
    req         = 8'h04;
    grant_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_grant", grant, 8'h04);
      chk("stall_valid", {7'b0, grant_valid}, 8'h01);
    end
    req = 8'h00;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("drop_grant", grant, 8'h04);
    end
    grant_ready = 1'b1;
    cycle();
    chk("release_grant", grant, 8'h00);
    chk("release_valid", {7'b0, grant_valid}, 8'h00);

    // Asynchronous reset in the middle of a grant
    do_reset();
    req         = 8'hff;
    grant_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", {7'b0, grant_valid}, 8'h01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 8'h00);
    chk("async_valid", {7'b0, grant_valid}, 8'h00);
    @(negedge clk);
    rst_n       = 1'b1;
    req         = 8'h03;
    grant_ready = 1'b1;
    cycle();
    chk("post_rst_grant", grant, 8'h01);

    // Mixed traffic against the model only
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req         = mix[i].r;
      grant_ready = mix[i].rdy;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
